// File: rtl/spi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and FSM encoding for the SPI receiver
//                (default word width, FIFO depth, receiver states).
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_WORD_W_DEFAULT = 16;
    localparam int c_FIFO_DEPTH     = 4;
    localparam int c_FIFO_PTR_W     = $clog2(c_FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_if
//  Description : SPI receiver bus bundle. Carries the raw SPI pins and the
//                received-word valid/ready stream plus error pulses.
//                slave  : receiver side (spi_rx)
//                master : transmitter / consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_rx_if
    import spi_pkg::*;
#(
    parameter int WORD_W = c_WORD_W_DEFAULT
) ();

    logic              SPI_CLK;
    logic              SPI_MOSI;
    logic              SPI_CS_N;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              overrun;
    logic              frame_err;

    modport slave (
        input  SPI_CLK, SPI_MOSI, SPI_CS_N, word_ready,
        output word_data, word_valid, overrun, frame_err
    );

    modport master (
        output SPI_CLK, SPI_MOSI, SPI_CS_N, word_ready,
        input  word_data, word_valid, overrun, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/spi_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_sync
//  Description : Multi-flop synchronizer for one asynchronous input bit.
//                Reset loads every stage with RST_VAL so the idle level of
//                the SPI line is seen while the chain refills.
//  Ports       : clk, reset (async, active-high), i_d (async in),
//                o_q (synchronized out)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= RST_VAL;
                else       r_sync <= i_d;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= {SYNC_STAGES{RST_VAL}};
                else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx
//  Description : SPI mode-0 slave receiver, oversampled by clk. SPI pins are
//                synchronized, SPI_CLK rising edges sample MOSI (MSB first)
//                into a WORD_W shift register; completed words go out on a
//                valid/ready stream.
//  Ports       : clk, reset (async, active-high), bus (spi_rx_if.slave)
//  Config      : SPI_RX_FIFO_EN defined   -> 4-deep output FIFO, a word
//                                            arriving when full is dropped
//                SPI_RX_FIFO_EN undefined -> single output register, a word
//                                            arriving while unaccepted
//                                            overwrites it
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rx
    import spi_pkg::*;
#(
    parameter int WORD_W      = c_WORD_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     reset,
    spi_rx_if.slave  bus
);

    localparam int                 c_CNT_W    = $clog2(WORD_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WORD_W);

    // ---------------------------------------------------------------- sync
    logic w_sclk;
    logic w_mosi;
    logic w_cs_n;

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .reset(reset), .i_d(bus.SPI_CLK), .o_q(w_sclk)
    );
    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
        .clk(clk), .reset(reset), .i_d(bus.SPI_MOSI), .o_q(w_mosi)
    );
    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .reset(reset), .i_d(bus.SPI_CS_N), .o_q(w_cs_n)
    );

    logic r_sclk_dly;
    logic w_sclk_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sclk_dly <= 1'b1;
        else       r_sclk_dly <= w_sclk;
    end

    assign w_sclk_rise = w_sclk & ~r_sclk_dly;

    // ----------------------------------------------------------------- FSM
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_clear;
    logic                w_shift_en;
    logic                w_frame_err_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic                w_word_done;
    logic                r_frame_err;
    logic                r_overrun;

    // The counter sits at WORD_W for exactly one cycle; that cycle is the
    // hand-off of the finished word to the output stage.
    assign w_word_done = (r_cnt == c_CNT_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clear         = 1'b0;
        w_shift_en      = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_n) begin
                    w_state_nxt = ST_SHIFT;
                    w_clear     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_n) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                    // A word finishing in this very cycle is still delivered,
                    // so it does not count as a truncated frame.
                    w_frame_err_nxt = (r_cnt != '0) && !w_word_done;
                end else begin
                    w_shift_en = w_sclk_rise;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // A shift cannot coincide with w_word_done: SPI_CLK rises are at least
    // four clk cycles apart, the done cycle follows a rise by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_word_done) begin
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[WORD_W-2:0], w_mosi};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_frame_err <= 1'b0;
        else       r_frame_err <= w_frame_err_nxt;
    end

    // -------------------------------------------------------- output stage
`ifdef SPI_RX_FIFO_EN
    localparam logic [c_FIFO_PTR_W:0] c_FIFO_FULL = (c_FIFO_PTR_W + 1)'(c_FIFO_DEPTH);

    logic [WORD_W-1:0]       r_mem [c_FIFO_DEPTH];
    logic [c_FIFO_PTR_W-1:0] r_wr_ptr;
    logic [c_FIFO_PTR_W-1:0] r_rd_ptr;
    logic [c_FIFO_PTR_W:0]   r_count;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push_ok;

    assign w_full    = (r_count == c_FIFO_FULL);
    assign w_pop     = (r_count != '0) & bus.word_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = w_word_done & (!w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_word_done & w_full & !w_pop;
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.word_data  = r_mem[r_rd_ptr];
    assign bus.word_valid = (r_count != '0);
`else
    logic [WORD_W-1:0] r_word;
    logic              r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_word_done & r_valid & ~bus.word_ready;
            if (w_word_done) begin
                // Covers the accept-and-refill cycle too: no valid gap.
                r_word  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid & bus.word_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.word_data  = r_word;
    assign bus.word_valid = r_valid;
`endif

    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
- REQ-001 SHALL have parameter WORD_W, default 16: bits per received word.
- REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per SPI input.
- REQ-003 SHALL have port clk  input  1: system clock; the only clock, all logic on rising edge.
- REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
- REQ-005 SHALL have port SPI_CLK  input  1: serial clock from the transmitter, asynchronous to clk.
- REQ-006 SHALL have port SPI_MOSI  input  1: serial data, changes on SPI_CLK falling edge, MSB first.
- REQ-007 SHALL have port SPI_CS_N  input  1: active-low frame select.
- REQ-008 SHALL have port word_data  output  WORD_W: received word.
- REQ-009 SHALL have port word_valid  output  1: word_data valid; held until accepted.
- REQ-010 SHALL have port word_ready  input  1: consumer accepts word when valid and ready are both high.
- REQ-011 SHALL have port overrun  output  1: one-clk pulse when a completed word is lost or overwrites an unaccepted word.
- REQ-012 SHALL have port frame_err  output  1: one-clk pulse when SPI_CS_N deasserts mid-word.

Function
- REQ-013 SHALL pass SPI_CLK, SPI_MOSI and SPI_CS_N through SYNC_STAGES flops each, then detect SPI_CLK rising edges by comparing the synchronized value with its one-cycle-delayed copy.
- REQ-014 SHALL support SPI_CLK frequency up to clk/4; faster SPI_CLK is out of scope.
- REQ-015 SHALL implement FSM IDLE, SHIFT: IDLE -> SHIFT when synchronized CS_N is low; SHIFT -> IDLE when synchronized CS_N is high.
- REQ-016 SHALL, in SHIFT on each SPI_CLK rising edge, shift synchronized MOSI into the LSB of a WORD_W shift register and increment a bit counter.
- REQ-017 SHALL, when the counter reaches WORD_W, present the word and wrap the counter to 0 in the same cycle, staying in SHIFT so back-to-back words need no CS toggle.
- REQ-018 SHALL assert word_valid exactly SYNC_STAGES+2 clk cycles after the raw SPI_CLK rising edge of the last bit, if the output was empty.
- REQ-019 SHALL clear word_valid in the cycle after a valid-and-ready handshake unless a new word completes in that same cycle, in which case the new word is presented without a gap.
- REQ-020 SHALL ignore SPI_CLK edges in IDLE and clear the bit counter and shift register on entering SHIFT.
- REQ-021 SHALL, on CS_N rising with counter nonzero, pulse frame_err, discard the partial word and leave word_valid/word_data untouched.
- REQ-022 SHALL pulse no frame_err when CS_N rises with counter 0.

Reset
- REQ-023 SHALL asynchronously force FSM=IDLE, counter=0, shift register=0, word_data=0, word_valid=0, overrun=0, frame_err=0, synchronizers to 1 (CS_N idle high, SPI_CLK/MOSI 1).
- REQ-024 SHALL, after reset release mid-frame, begin shifting only after the next synchronized CS_N low is observed.

Configuration
- REQ-025 SHALL provide macro SPI_RX_FIFO_EN: when defined, completed words enter a 4-deep FIFO; word_data/word_valid show FIFO head; overrun pulses and the new word is dropped when the FIFO is full.
- REQ-026 SHALL, without SPI_RX_FIFO_EN, use a single output register; a word completing while word_valid high and word_ready low overwrites word_data and pulses overrun.
- REQ-027 SHALL, with SPI_RX_FIFO_EN, allow simultaneous push and pop when full without overrun.

Structure
- REQ-028 SHALL place WORD_W default, FIFO depth constant (4) and the FSM state encoding in shared package spi_pkg.
- REQ-029 SHALL instantiate sub-module spi_rx_sync (parameterized SYNC_STAGES, reset value input) once per SPI input.

Verification
- REQ-030 SHALL cover: CS_N low, send 0xA5C3 at clk/8, word_ready=1 -> one word_valid pulse, word_data=0xA5C3, no errors.
- REQ-031 SHALL cover: three words 0x0001, 0x8000, 0xFFFF in one frame -> three words in order, no frame_err.
- REQ-032 SHALL cover: CS_N rises after 9 bits of 0x1234 -> frame_err one pulse, no word_valid; next full frame 0x5678 received correctly.
- REQ-033 SHALL cover: word_ready=0, two words sent -> without FIFO overrun=1 once and word_data=second word; with FIFO both held, second appears after first accepted.
- REQ-034 SHALL cover: with FIFO, word_ready=0, five words -> overrun on fifth, first four drained in order.
- REQ-035 SHALL cover: reset asserted after 8 bits -> all outputs 0 immediately; following frame 0xBEEF received correctly.
